// File: rtl/ama_riscv_defines.sv
// Shared RISC-V core definitions: branch outcome, predictor update strobes
// and the speculation-tracker state encoding.
package ama_riscv_defines;

  typedef enum logic {
    B_NT = 1'b0,
    B_T  = 1'b1
  } branch_t;

  typedef struct packed {
    logic enter;
    logic resolve;
  } spec_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPEC  = 2'd1,
    FLUSH = 2'd2
  } spec_state_t;

endpackage

// File: rtl/ama_riscv_sat_cnt.sv
// Parameterized up-counter that sticks at all-ones instead of wrapping.
module ama_riscv_sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_r;

  // count up on inc, hold once every bit is set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {W{1'b0}};
    end else if (inc && (cnt_r != {W{1'b1}})) begin
      cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/ama_riscv_bp_spec.sv
// Branch speculation tracker: one conditional branch in flight between decode
// and execute. Optional statistics counters with AMA_RISCV_BP_STATS_EN.
module ama_riscv_bp_spec
  import ama_riscv_defines::*;
#(
  parameter int CNT_W = 32
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    dec_br,
  input  logic    dec_stall,
  input  branch_t pred,
  input  logic    exe_br,
  input  branch_t br_res,
  output spec_t   spec,
  output branch_t pred_made,
  output logic    mispred,
  output logic    redirect_t,
  output logic    flush,
  output logic    dec_hold
`ifdef AMA_RISCV_BP_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_br,
  output logic [CNT_W-1:0] stat_mispred
`endif
);

  spec_state_t state_r;
  spec_state_t state_nxt_s;
  branch_t     pred_made_r;
  logic        flush_r;
  logic        enter_s;
  logic        resolve_s;
  logic        mispred_s;
  logic        redirect_s;
  logic        dec_hold_s;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // next-state logic; strobes below are already gated by rst_n
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (enter_s) begin
          state_nxt_s = SPEC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SPEC: begin
        if (!exe_br) begin
          state_nxt_s = SPEC;
        end else if (mispred_s) begin
          state_nxt_s = FLUSH;
        end else if (enter_s) begin
          state_nxt_s = SPEC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FLUSH:   state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // combinational strobes; all forced low while reset is asserted
  always_comb begin
    enter_s    = 1'b0;
    resolve_s  = 1'b0;
    mispred_s  = 1'b0;
    redirect_s = 1'b0;
    dec_hold_s = 1'b0;
    if (rst_n) begin
      case (state_r)
        IDLE: begin
          enter_s = dec_br & ~dec_stall;
        end
        SPEC: begin
          if (exe_br) begin
            resolve_s  = 1'b1;
            mispred_s  = (br_res != pred_made_r);
            redirect_s = mispred_s & (br_res == B_T);
            // a mispredicting resolve must not let the wrong-path branch in
            enter_s    = ~mispred_s & dec_br & ~dec_stall;
          end else begin
            dec_hold_s = dec_br;
          end
        end
        FLUSH: begin
          enter_s = 1'b0;
        end
        default: begin
          enter_s = 1'b0;
        end
      endcase
    end else begin
      enter_s = 1'b0;
    end
  end

  // prediction latched at each enter, held in between
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_made_r <= B_NT;
    end else if (enter_s) begin
      pred_made_r <= pred;
    end else begin
      pred_made_r <= pred_made_r;
    end
  end

  // one-cycle flush pulse following a mispredict
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_r <= 1'b0;
    end else begin
      flush_r <= mispred_s;
    end
  end

  assign spec.enter   = enter_s;
  assign spec.resolve = resolve_s;
  assign pred_made    = pred_made_r;
  assign mispred      = mispred_s;
  assign redirect_t   = redirect_s;
  assign flush        = flush_r;
  assign dec_hold     = dec_hold_s;

`ifdef AMA_RISCV_BP_STATS_EN
  ama_riscv_sat_cnt #(.W(CNT_W)) u_stat_br (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (resolve_s),
    .cnt   (stat_br)
  );

  ama_riscv_sat_cnt #(.W(CNT_W)) u_stat_mispred (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (mispred_s),
    .cnt   (stat_mispred)
  );
`endif

endmodule
